// File: rtl/jtgng_ram_arb.sv
// Single-port RAM sequencer: clears the RAM after reset, then arbitrates
// CPU read/write (port A) and video read (port B) with a req/ack handshake.
module jtgng_ram_arb #(
  parameter int              DW      = 8,
  parameter int              AW      = 10,
  parameter logic [DW-1:0]   CLR_VAL = {DW{1'b0}},
  parameter bit              PRIO_B  = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic [DW-1:0] a_dout,
  output logic          a_ack,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_dout,
  output logic          b_ack,
  output logic          clr_busy,
  output logic          ram_cen,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  input  logic [DW-1:0] ram_q
);

  localparam logic [1:0]  ST_CLEAR = 2'd0;
  localparam logic [1:0]  ST_IDLE  = 2'd1;
  localparam logic [1:0]  ST_ACC   = 2'd2;
  localparam logic [1:0]  ST_DATA  = 2'd3;
  localparam logic [AW:0] CNT_END  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

  logic [1:0]  state_r;
  logic [AW:0] cnt_r;
  logic        owner_b_r;
  logic        wr_r;
  logic        last_b_r;
  logic        a_elig_s;
  logic        b_elig_s;
  logic        grant_s;
  logic        grant_b_s;

  // A port whose ack is high this cycle must not be re-served on the same edge
  assign a_elig_s = a_req & ~a_ack;
  assign b_elig_s = b_req & ~b_ack;
  assign grant_s  = a_elig_s | b_elig_s;

  // Grant selection: fixed B priority or round-robin against the last owner
  always_comb begin
    grant_b_s = 1'b0;
    if (a_elig_s && b_elig_s) begin
      if (PRIO_B) begin
        grant_b_s = 1'b1;
      end else begin
        grant_b_s = ~last_b_r;
      end
    end else begin
      grant_b_s = b_elig_s;
    end
  end

  // Sequencer: clear sweep, then grant -> access -> data/ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_CLEAR;
      cnt_r     <= {(AW+1){1'b0}};
      owner_b_r <= 1'b0;
      wr_r      <= 1'b0;
      last_b_r  <= 1'b1;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_dout    <= {DW{1'b0}};
      b_dout    <= {DW{1'b0}};
      clr_busy  <= 1'b1;
      ram_cen   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= {AW{1'b0}};
      ram_data  <= {DW{1'b0}};
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state_r)
        ST_CLEAR: begin
          if (cnt_r == CNT_END) begin
            ram_cen  <= 1'b0;
            ram_we   <= 1'b0;
            clr_busy <= 1'b0;
            state_r  <= ST_IDLE;
          end else begin
            ram_cen  <= 1'b1;
            ram_we   <= 1'b1;
            ram_addr <= cnt_r[AW-1:0];
            ram_data <= CLR_VAL;
            cnt_r    <= cnt_r + CNT_ONE;
          end
        end
        ST_IDLE: begin
          if (grant_s) begin
            ram_cen   <= 1'b1;
            owner_b_r <= grant_b_s;
            state_r   <= ST_ACC;
            if (grant_b_s) begin
              ram_addr <= b_addr;
              ram_we   <= 1'b0;
              wr_r     <= 1'b0;
            end else begin
              ram_addr <= a_addr;
              ram_we   <= a_we;
              wr_r     <= a_we;
              ram_data <= a_din;
            end
          end else begin
            ram_cen <= 1'b0;
            ram_we  <= 1'b0;
          end
        end
        ST_ACC: begin
          ram_cen <= 1'b0;
          ram_we  <= 1'b0;
          state_r <= ST_DATA;
        end
        ST_DATA: begin
          if (owner_b_r) begin
            b_dout <= ram_q;
            b_ack  <= 1'b1;
          end else begin
            a_ack <= 1'b1;
            if (!wr_r) begin
              a_dout <= ram_q;
            end
          end
          last_b_r <= owner_b_r;
          state_r  <= ST_IDLE;
        end
        default: begin
          ram_cen <= 1'b0;
          ram_we  <= 1'b0;
          state_r <= ST_CLEAR;
        end
      endcase
    end
  end

endmodule
